// File: rtl/pwm_duty_gen.sv
// 10-slot PWM generator driven by an external 0..9 decade count.
// Duty is adjusted by debounced up/down buttons and only changes on period boundaries.
module pwm_duty_gen #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic [3:0] cont_i,
  input  logic       up_i,
  input  logic       dn_i,
  output logic       pwm_o,
  output logic [3:0] duty_o,
  output logic       pend_o,
  output logic       err_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam int UP = 0;
  localparam int DN = 1;

  logic [1:0]         s1_q, s2_q;
  logic [1:0]         stable_q, stable_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         press;
  logic [3:0]         duty_req_q, duty_req_d;
  logic [3:0]         duty_q, duty_d;
  logic               pwm_q, pwm_d;
  logic               pend_q, pend_d;
  logic               err_q, err_d;
  logic               cont_ok;

  // Debounce: a state change is accepted only after DB_CYCLES differing samples in a row.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press    = '0;
    for (int b = 0; b < 2; b++) begin
      if (s2_q[b] != stable_q[b]) begin
        if (cnt_q[b] == DB_LAST) begin
          stable_d[b] = s2_q[b];
          press[b]    = s2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    duty_req_d = duty_req_q;
    case (press)
      2'b01:   if (duty_req_q < 4'd10) duty_req_d = duty_req_q + 4'd1;
      2'b10:   if (duty_req_q > 4'd0)  duty_req_d = duty_req_q - 4'd1;
      default: duty_req_d = duty_req_q;
    endcase
  end

  // The slot-9 compare still uses the old duty; the new one starts at slot 0.
  always_comb begin
    cont_ok = (cont_i <= 4'd9);
    duty_d  = (cont_ok && cont_i == 4'd9) ? duty_req_q : duty_q;
    pwm_d   = cont_ok && (cont_i < duty_q);
    err_d   = err_q | ~cont_ok;
    pend_d  = (duty_req_d != duty_d);
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      duty_req_q <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_q       <= {dn_i, up_i};
      s2_q       <= s1_q;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      duty_req_q <= duty_req_d;
      duty_q     <= duty_d;
      pwm_q      <= pwm_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign duty_o = duty_q;
  assign pend_o = pend_q;
  assign err_o  = err_q;

  // Index constants kept for readability of the press vector ordering.
  logic unused_idx;
  assign unused_idx = (UP == 0) && (DN == 1);

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Directed bench for pwm_duty_gen: free-running decade count, button presses, debounce,
// saturation, mid-period duty change, error and reset.
module tb_pwm_duty_gen;

  logic       clk_i = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cont_i = 4'd0;
  logic       up_i = 1'b0;
  logic       dn_i = 1'b0;
  logic       pwm_o;
  logic [3:0] duty_o;
  logic       pend_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;
  logic [3:0] c_edge;

  pwm_duty_gen #(.DB_CYCLES(4)) dut (
    .clk_i (clk_i),
    .reset (reset),
    .cont_i(cont_i),
    .up_i  (up_i),
    .dn_i  (dn_i),
    .pwm_o (pwm_o),
    .duty_o(duty_o),
    .pend_o(pend_o),
    .err_o (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  // One clock: remember the count seen at the edge, sample #1 later, advance the count.
  task automatic tick();
    c_edge = cont_i;
    @(posedge clk_i);
    #1;
    cont_i = (cont_i >= 4'd9) ? 4'd0 : cont_i + 4'd1;
  endtask

  task automatic press(input bit is_up, input bit chk_p);
    if (is_up) up_i = 1'b1; else dn_i = 1'b1;
    repeat (6) tick();
    if (chk_p) chk("press_pend", pend_o, 1);
    repeat (2) tick();
    up_i = 1'b0;
    dn_i = 1'b0;
    repeat (8) tick();
  endtask

  task automatic wait_load();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (c_edge == 4'd9) seen = 1'b1;
    end
    chk("load_seen", seen, 1);
  endtask

  task automatic wait_cont9();
    for (int i = 0; i < 12 && cont_i != 4'd9; i++) tick();
    chk("cont9_reached", cont_i, 9);
  endtask

  initial begin
    int hi;
    int d_before;
    int exp_d;

    // Reset, then idle for three periods
    repeat (2) tick();
    chk("rst_pwm", pwm_o, 0);
    chk("rst_duty", duty_o, 0);
    chk("rst_pend", pend_o, 0);
    chk("rst_err", err_o, 0);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("idle_pwm", pwm_o, 0);
      chk("idle_duty", duty_o, 0);
      chk("idle_pend", pend_o, 0);
      chk("idle_err", err_o, 0);
    end

    // Three up presses, then 3/10 duty
    for (int i = 0; i < 3; i++) press(1'b1, 1'b1);
    wait_load();
    chk("up3_duty", duty_o, 3);
    chk("up3_pend", pend_o, 0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("up3_pwm", pwm_o, int'(c_edge < 4'd3));
      hi += int'(pwm_o);
    end
    chk("up3_hicount", hi, 3);

    // Saturation at 10 and at 0
    for (int i = 0; i < 12; i++) press(1'b1, i < 7);
    wait_load();
    chk("sat_hi_duty", duty_o, 10);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sat_hi_pwm", pwm_o, 1);
    end
    for (int i = 0; i < 12; i++) press(1'b0, i < 10);
    wait_load();
    chk("sat_lo_duty", duty_o, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("sat_lo_pwm", pwm_o, 0);
    end

    // Debounce: bursts of 3 are rejected, a hold gives one press at k+5
    for (int i = 0; i < 8; i++) begin
      up_i = (i % 4 != 3);
      tick();
      chk("glitch_pend", pend_o, 0);
    end
    up_i = 1'b1;
    repeat (5) tick();
    chk("db_k4_pend", pend_o, 0);
    tick();
    chk("db_k5_pend", pend_o, 1);
    repeat (2) tick();
    up_i = 1'b0;
    repeat (8) tick();
    wait_load();
    chk("db_duty", duty_o, 1);

    // Simultaneous up and down
    up_i = 1'b1;
    dn_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        up_i = 1'b0;
        dn_i = 1'b0;
      end
      tick();
      chk("both_pend", pend_o, 0);
    end
    chk("both_duty", duty_o, 1);

    for (int i = 0; i < 3; i++) press(1'b1, 1'b1);
    wait_load();
    chk("up4_duty", duty_o, 4);
    chk("up4_pend", pend_o, 0);

    // Press lands at slot 4: finish period at 4/10, then 5/10 from slot 0
    wait_cont9();
    up_i = 1'b1;
    repeat (6) tick();
    chk("mid_slot", c_edge, 4);
    chk("mid_pend", pend_o, 1);
    chk("mid_duty_old", duty_o, 4);
    exp_d = 4;
    for (int i = 0; i < 14; i++) begin
      d_before = exp_d;
      tick();
      chk("mid_pwm", pwm_o, int'(int'(c_edge) < d_before));
      if (c_edge == 4'd9) exp_d = 5;
      chk("mid_duty", duty_o, exp_d);
    end
    up_i = 1'b0;
    repeat (8) tick();

    // Second mid-period press, then an out-of-range count replaces slot 9
    wait_cont9();
    up_i = 1'b1;
    repeat (6) tick();
    chk("mid2_pend", pend_o, 1);
    repeat (4) tick();
    chk("pre_err", err_o, 0);
    cont_i = 4'd12;
    tick();
    chk("err_flag", err_o, 1);
    chk("err_pwm", pwm_o, 0);
    chk("err_noload", duty_o, 5);
    chk("err_pend", pend_o, 1);
    tick();
    chk("err_resume_pwm", pwm_o, 1);
    chk("err_sticky", err_o, 1);
    chk("err_duty5", duty_o, 5);

    // Reset mid-operation
    up_i = 1'b0;
    reset = 1'b1;
    tick();
    chk("mrst_pwm", pwm_o, 0);
    chk("mrst_duty", duty_o, 0);
    chk("mrst_pend", pend_o, 0);
    chk("mrst_err", err_o, 0);
    reset = 1'b0;
    wait_load();
    chk("post_rst_duty", duty_o, 0);
    chk("post_rst_pend", pend_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
